// File: rtl/serial_adder.sv
// Bit-serial ripple adder: operands are captured on START, summed LSB first
// over N RUN cycles, and the registered result is presented with a DONE pulse.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic [N-1:0] S,
    output logic         COUT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic [N-1:0]   sum_sr;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic half_sum;
    logic half_gen;
    logic sum_bit;
    logic carry_next;

    // One full-adder slice built from two half adders and an OR.
    always_comb begin
        half_sum   = sa[0] ^ sb[0];
        half_gen   = sa[0] & sb[0];
        sum_bit    = half_sum ^ carry;
        carry_next = half_gen | (half_sum & carry);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            COUT   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        sa     <= A;
                        sb     <= B;
                        carry  <= CIN;
                        cnt    <= '0;
                        sum_sr <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= {sum_bit, sum_sr[N-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    // The last slice goes straight into S so the result is
                    // visible in the same cycle DONE rises.
                    if (cnt == LAST_BIT) begin
                        S     <= {sum_bit, sum_sr[N-1:1]};
                        COUT  <= carry_next;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at N=8: reset, latency,
// carry chains, input isolation, abort and back-to-back operation.
module tb_serial_adder;

    localparam int N = 8;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic [N-1:0] S;
    logic         COUT;
    logic         BUSY;
    logic         DONE;

    int total_checks;
    int passed_checks;

    serial_adder #(.N(N)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .S     (S),
        .COUT  (COUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle, so outputs are sampled off the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Present operands with a one-edge START pulse.
    task automatic applyStimulus(input logic [N-1:0] a_val, input logic [N-1:0] b_val,
                                 input logic cin_val);
        A     = a_val;
        B     = b_val;
        CIN   = cin_val;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (DONE !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (DONE !== 1'b1) checkOutput({tag, "_timeout"}, 32'(DONE), 32'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [N-1:0] a_val,
                               input logic [N-1:0] b_val, input logic cin_val,
                               input logic [N:0] expected);
        int cycles;
        applyStimulus(a_val, b_val, cin_val);
        waitDone(tag, 2 * N, cycles);
        checkOutput(tag, 32'({COUT, S}), 32'(expected));
        tick();
    endtask

    initial begin
        int cycles;
        int done_count;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [N:0]   rexp;

        total_checks  = 0;
        passed_checks = 0;
        RST   = 1'b1;
        START = 1'b0;
        A     = '0;
        B     = '0;
        CIN   = 1'b0;

        // Reset, then idle with START low.
        tick();
        tick();
        checkOutput("reset_outputs", 32'({S, COUT, BUSY, DONE}), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("idle_%0d", i), 32'({S, COUT, BUSY, DONE}), 32'd0);
        end

        // Basic add with cycle-accurate BUSY/DONE timing.
        applyStimulus(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("basic_busy_%0d", i), 32'({BUSY, DONE}), 32'b10);
            tick();
        end
        checkOutput("basic_done_flags", 32'({BUSY, DONE}), 32'b01);
        checkOutput("basic_sum", 32'({COUT, S}), 32'h010);
        tick();
        checkOutput("basic_done_drop", 32'({BUSY, DONE}), 32'b00);
        checkOutput("basic_sum_hold", 32'({COUT, S}), 32'h010);

        // Full carry chains.
        runAndCheck("carry_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
        runAndCheck("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        runAndCheck("mixed_3c_5a", 8'h3C, 8'h5A, 1'b1, 9'h097);

        // Operands and START changing during RUN must not disturb the result.
        applyStimulus(8'h55, 8'hAA, 1'b1);
        A     = 8'h00;
        B     = 8'h00;
        CIN   = 1'b0;
        START = 1'b1;
        done_count = 0;
        for (int i = 0; i < 14; i++) begin
            if (DONE === 1'b1) begin
                done_count++;
                checkOutput("hold_sum", 32'({COUT, S}), 32'h100);
                START = 1'b0;
            end
            tick();
        end
        START = 1'b0;
        checkOutput("hold_done_count", 32'(done_count), 32'd1);

        // Reset in the middle of RUN aborts the operation.
        applyStimulus(8'h80, 8'h80, 1'b0);
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE === 1'b1) done_count++;
            tick();
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_outputs", 32'({S, COUT, BUSY}), 32'd0);
        runAndCheck("abort_restart", 8'h80, 8'h80, 1'b0, 9'h100);

        // START held high: one result every N+2 cycles.
        A     = 8'h01;
        B     = 8'h02;
        CIN   = 1'b0;
        START = 1'b1;
        waitDone("b2b_first", 2 * N, cycles);
        checkOutput("b2b_sum_first", 32'({COUT, S}), 32'h003);
        tick();
        waitDone("b2b_second", 2 * N, cycles);
        checkOutput("b2b_period", 32'(cycles + 1), 32'(N + 2));
        checkOutput("b2b_sum_second", 32'({COUT, S}), 32'h003);
        START = 1'b0;
        tick();
        tick();
        checkOutput("b2b_idle", 32'({BUSY, DONE}), 32'b00);

        // Random pairs, with operands scrambled while the addition runs.
        for (int i = 0; i < 256; i++) begin
            ra   = N'($urandom);
            rb   = N'($urandom);
            rc   = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
            applyStimulus(ra, rb, rc);
            A   = N'($urandom);
            B   = N'($urandom);
            CIN = 1'($urandom);
            waitDone($sformatf("rand_%0d", i), 2 * N, cycles);
            checkOutput($sformatf("rand_%0d_%02h_%02h_%0d", i, ra, rb, rc),
                        32'({COUT, S}), 32'(rexp));
            tick();
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
